// File: rtl/layer_sequencer.sv
// -----------------------------------------------------------------------------
// layer_sequencer
//
// Frame-level controller for one fully-connected layer of neurons.
// One input vector is accepted per frame on a valid/ready stream and held in a
// single-port-style buffer. The vector is then broadcast to every neuron as one
// gap-free burst. Each neuron's activation is captured on its first outvalid
// pulse. The result vector is streamed downstream, where it feeds the next
// layer. A watchdog bounds the wait for neuron results and raises a sticky
// error flag.
//
// Ports
//   clk           clock, rising edge
//   rst           asynchronous reset, active low
//   in_data       input vector word
//   in_valid      in_data valid
//   in_ready      sequencer can accept in_data (IDLE/LOAD only)
//   nrn_data      broadcast word to all neurons
//   nrn_valid     broadcast valid, numInputs contiguous cycles per frame
//   nrn_out       neuron outputs, neuron i at [i*dataWidth +: dataWidth]
//   nrn_outvalid  per-neuron output-valid pulses
//   out_data      result vector word
//   out_valid     out_data valid (DRAIN)
//   out_ready     downstream accepts out_data
//   out_last      high with the final result word
//   busy          frame in progress (state != IDLE)
//   err           sticky timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module layer_sequencer #(
    parameter int numInputs  = 784,
    parameter int numNeurons = 30,
    parameter int dataWidth  = 16,
    parameter int timeoutCyc = 4096
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [dataWidth-1:0]             in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic [dataWidth-1:0]             nrn_data,
    output logic                             nrn_valid,
    input  logic [numNeurons*dataWidth-1:0]  nrn_out,
    input  logic [numNeurons-1:0]            nrn_outvalid,
    output logic [dataWidth-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic                             busy,
    output logic                             err
);

    localparam int WW = $clog2(numInputs + 1);
    localparam int AW = (numInputs > 1) ? $clog2(numInputs) : 1;
    localparam int RW = $clog2(numNeurons + 1);
    localparam int NW = (numNeurons > 1) ? $clog2(numNeurons) : 1;
    localparam int TW = $clog2(timeoutCyc + 1);

    localparam logic [WW-1:0] LAST_W = WW'(numInputs - 1);
    localparam logic [WW-1:0] NUM_W  = WW'(numInputs);
    localparam logic [RW-1:0] LAST_R = RW'(numNeurons - 1);
    localparam logic [TW-1:0] TMO    = TW'(timeoutCyc);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        BCAST = 3'd2,
        WAIT  = 3'd3,
        DRAIN = 3'd4
    } state_t;

    state_t state_reg, state_next;

    logic                  in_ready_reg;
    logic [WW-1:0]         wcnt_reg;
    logic [WW-1:0]         rd_idx_reg;
    logic                  rd_en_d1_reg;
    logic [dataWidth-1:0]  rd_data_reg;
    logic [dataWidth-1:0]  nrn_data_reg;
    logic                  nrn_valid_reg;
    logic [TW-1:0]         tcnt_reg;
    logic [RW-1:0]         rcnt_reg;
    logic [numNeurons-1:0] done_reg, done_next;
    logic                  err_reg;
    logic [dataWidth-1:0]  obuf_reg [numNeurons];
    logic [dataWidth-1:0]  nrn_word [numNeurons];
    logic [dataWidth-1:0]  ibuf [numInputs];

    logic          in_fire;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic          all_done;
    logic          timeout;

    // Per-neuron view of the packed neuron output bus.
    generate
        for (genvar gi = 0; gi < numNeurons; gi++) begin : g_slice
            assign nrn_word[gi] = nrn_out[gi*dataWidth +: dataWidth];
        end
    endgenerate

    assign in_fire = in_valid && in_ready_reg;
    assign wr_en   = in_fire && ((state_reg == IDLE) || (state_reg == LOAD));
    assign wr_addr = (state_reg == IDLE) ? '0 : wcnt_reg[AW-1:0];
    assign rd_en   = (state_reg == BCAST) && (rd_idx_reg != NUM_W);

    // Input buffer: plain array with registered read so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ibuf[wr_addr] <= in_data;
        end
        if (rd_en) begin
            rd_data_reg <= ibuf[rd_idx_reg[AW-1:0]];
        end
    end

    // Done bits include this cycle's pulses so DRAIN follows the completing
    // pulse by one cycle; a neuron already done ignores repeats.
    always_comb begin
        done_next = done_reg;
        if (state_reg == IDLE) begin
            done_next = '0;
        end else if (state_reg == WAIT) begin
            done_next = done_reg | nrn_outvalid;
        end
    end

    assign all_done = &done_next;
    assign timeout  = (state_reg == WAIT) && !all_done && (tcnt_reg == TMO);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (in_fire) begin
                    state_next = (numInputs == 1) ? BCAST : LOAD;
                end
            end
            LOAD: begin
                if (in_fire && (wcnt_reg == LAST_W)) begin
                    state_next = BCAST;
                end
            end
            BCAST: begin
                // All reads issued, pipeline drained, last word on the bus now.
                if ((rd_idx_reg == NUM_W) && !rd_en_d1_reg && nrn_valid_reg) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (all_done || timeout) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (out_ready && (rcnt_reg == LAST_R)) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_ready_reg  <= 1'b0;
            wcnt_reg      <= '0;
            rd_idx_reg    <= '0;
            rd_en_d1_reg  <= 1'b0;
            nrn_data_reg  <= '0;
            nrn_valid_reg <= 1'b0;
            tcnt_reg      <= '0;
            rcnt_reg      <= '0;
            done_reg      <= '0;
            err_reg       <= 1'b0;
        end else begin
            // Registered so in_ready stays low while reset is held and for the
            // first cycle after release.
            in_ready_reg <= (state_next == IDLE) || (state_next == LOAD);

            if (wr_en) begin
                wcnt_reg <= (state_reg == IDLE) ? WW'(1) : wcnt_reg + 1'b1;
            end

            if (rd_en) begin
                rd_idx_reg <= rd_idx_reg + 1'b1;
            end else if (state_reg != BCAST) begin
                rd_idx_reg <= '0;
            end

            // Two-stage broadcast pipeline: RAM read register, then output register.
            rd_en_d1_reg  <= rd_en;
            nrn_valid_reg <= rd_en_d1_reg;
            if (rd_en_d1_reg) begin
                nrn_data_reg <= rd_data_reg;
            end

            tcnt_reg <= (state_reg == WAIT) ? tcnt_reg + 1'b1 : '0;

            if (state_reg == DRAIN) begin
                if (out_ready) begin
                    rcnt_reg <= (rcnt_reg == LAST_R) ? '0 : rcnt_reg + 1'b1;
                end
            end else begin
                rcnt_reg <= '0;
            end

            done_reg <= done_next;

            if (timeout) begin
                err_reg <= 1'b1;
            end
        end
    end

    // Result buffer: first pulse per neuron wins; on timeout every neuron that
    // never reported reads back as zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < numNeurons; i++) begin
                obuf_reg[i] <= '0;
            end
        end else if (state_reg == WAIT) begin
            for (int i = 0; i < numNeurons; i++) begin
                if (nrn_outvalid[i] && !done_reg[i]) begin
                    obuf_reg[i] <= nrn_word[i];
                end else if (timeout && !done_reg[i]) begin
                    obuf_reg[i] <= '0;
                end
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign nrn_data  = nrn_data_reg;
    assign nrn_valid = nrn_valid_reg;
    assign out_valid = (state_reg == DRAIN);
    assign out_data  = (state_reg == DRAIN) ? obuf_reg[rcnt_reg[NW-1:0]] : '0;
    assign out_last  = (state_reg == DRAIN) && (rcnt_reg == LAST_R);
    assign busy      = (state_reg != IDLE);
    assign err       = err_reg;

endmodule

// File: tb/tb_layer_sequencer.sv
// -----------------------------------------------------------------------------
// tb_layer_sequencer
//
// Directed frame sequence with randomized data, upstream/downstream stalls and
// spurious neuron pulses outside WAIT. Expected burst contents, result words,
// drain start and error flag come from a frame-level model of the layer
// (first pulse per neuron wins, zero for neurons that never report).
// -----------------------------------------------------------------------------
module tb_layer_sequencer;

    localparam int NI  = 4;
    localparam int NN  = 3;
    localparam int DW  = 16;
    localparam int TMO = 16;
    localparam int OW  = NN * DW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] nrn_data;
    logic          nrn_valid;
    logic [OW-1:0] nrn_out = '0;
    logic [NN-1:0] nrn_outvalid = '0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          err;

    layer_sequencer #(
        .numInputs (NI),
        .numNeurons(NN),
        .dataWidth (DW),
        .timeoutCyc(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .nrn_data    (nrn_data),
        .nrn_valid   (nrn_valid),
        .nrn_out     (nrn_out),
        .nrn_outvalid(nrn_outvalid),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .busy        (busy),
        .err         (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] vec [NI];
    int            s_off [8];
    int            s_nrn [8];
    logic [DW-1:0] s_val [8];
    int            s_n = 0;
    bit            err_model = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic noise_pulses();
        nrn_outvalid = NN'($urandom);
        nrn_out      = OW'({$urandom(), $urandom()});
    endtask

    task automatic sched_add(input int off, input int n);
        s_off[s_n] = off;
        s_nrn[s_n] = n;
        s_val[s_n] = DW'($urandom);
        s_n++;
    endtask

    task automatic new_vec();
        for (int i = 0; i < NI; i++) vec[i] = DW'($urandom);
    endtask

    task automatic send_vec(input bit stall);
        int idx = 0;
        int guard = 0;
        while (idx < NI && guard < 200) begin
            @(negedge clk);
            guard++;
            noise_pulses();
            if (stall && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = vec[idx];
                if (in_ready) idx++;
            end
        end
        chk("load_accepts", 32'(idx), 32'(NI));
    endtask

    task automatic capture_burst();
        int k = 0;
        int cnt = 0;
        int first_k = -1;
        logic [DW-1:0] got [$];
        while (k < 60) begin
            @(negedge clk);
            if (k == 0) begin
                in_valid = 1'b0;
                chk("bcast_in_ready", 32'(in_ready), 32'(0));
                chk("bcast_busy", 32'(busy), 32'(1));
            end
            if (nrn_valid) begin
                if (cnt == 0) first_k = k;
                got.push_back(nrn_data);
                cnt++;
            end else if (cnt > 0) begin
                break;
            end
            if (cnt < NI) noise_pulses();
            else nrn_outvalid = '0;
            k++;
        end
        nrn_outvalid = '0;
        chk("burst_len", 32'(cnt), 32'(NI));
        chk("burst_start", 32'(first_k), 32'(2));
        for (int i = 0; i < NI && i < cnt; i++) begin
            chk($sformatf("burst_word%0d", i), 32'(got[i]), 32'(vec[i]));
        end
        chk("nrn_valid_after", 32'(nrn_valid), 32'(0));
        chk("nrn_data_hold", 32'(nrn_data), 32'(vec[NI-1]));
    endtask

    task automatic wait_and_drain(input bit stall_out);
        logic [DW-1:0] exp_out [NN];
        bit got [NN];
        int ngot = 0;
        int complete_off = -1;
        int exp_start;
        int c = 0;
        int start = -1;
        int idx = 0;
        int g = 0;
        // Frame-level model: first pulse per neuron counts until all reported.
        for (int i = 0; i < NN; i++) begin
            exp_out[i] = '0;
            got[i] = 1'b0;
        end
        for (int j = 0; j < s_n; j++) begin
            if (complete_off < 0 && s_off[j] <= TMO && !got[s_nrn[j]]) begin
                got[s_nrn[j]] = 1'b1;
                exp_out[s_nrn[j]] = s_val[j];
                ngot++;
                if (ngot == NN) complete_off = s_off[j];
            end
        end
        exp_start = (complete_off >= 0) ? complete_off + 1 : TMO + 1;
        if (complete_off < 0) err_model = 1'b1;

        while (c < 100) begin
            if (c > 0) @(negedge clk);
            if (out_valid) begin
                start = c;
                break;
            end
            nrn_outvalid = '0;
            for (int j = 0; j < s_n; j++) begin
                if (s_off[j] == c) begin
                    nrn_outvalid[s_nrn[j]] = 1'b1;
                    nrn_out[s_nrn[j]*DW +: DW] = s_val[j];
                end
            end
            c++;
        end
        if (complete_off >= 0) begin
            chk("drain_start", 32'(start), 32'(exp_start));
        end else begin
            chk("drain_start_timeout", 32'((start == TMO) || (start == TMO + 1)), 32'(1));
        end
        chk("err_at_drain", 32'(err), 32'(err_model));

        while (idx < NN && g < 200) begin
            if (g > 0) @(negedge clk);
            g++;
            chk("out_valid", 32'(out_valid), 32'(1));
            chk($sformatf("out_word%0d", idx), 32'(out_data), 32'(exp_out[idx]));
            chk("out_last", 32'(out_last), 32'(idx == NN - 1));
            noise_pulses();
            out_ready = (stall_out && $urandom_range(0, 1) == 0) ? 1'b0 : 1'b1;
            if (out_ready) idx++;
        end
        @(negedge clk);
        out_ready    = 1'b0;
        nrn_outvalid = '0;
        chk("end_out_valid", 32'(out_valid), 32'(0));
        chk("end_busy", 32'(busy), 32'(0));
        chk("end_in_ready", 32'(in_ready), 32'(1));
        chk("end_err", 32'(err), 32'(err_model));
    endtask

    task automatic frame(input bit stall_in, input bit stall_out);
        new_vec();
        send_vec(stall_in);
        capture_burst();
        wait_and_drain(stall_out);
    endtask

    initial begin
        int cnt;
        // Reset held with random inputs: every output must stay zero.
        #2 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom);
            in_data   = DW'($urandom);
            out_ready = 1'($urandom);
            noise_pulses();
            #1;
            chk("rst_in_ready", 32'(in_ready), 32'(0));
            chk("rst_nrn_valid", 32'(nrn_valid), 32'(0));
            chk("rst_nrn_data", 32'(nrn_data), 32'(0));
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_out_last", 32'(out_last), 32'(0));
            chk("rst_out_data", 32'(out_data), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_err", 32'(err), 32'(0));
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        nrn_outvalid = '0;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'(1));
        chk("post_rst_busy", 32'(busy), 32'(0));

        // Basic frame: all neurons report 5 cycles after the burst.
        s_n = 0;
        sched_add(5, 0); sched_add(5, 1); sched_add(5, 2);
        frame(1'b0, 1'b0);

        // Upstream and downstream stalls.
        s_n = 0;
        sched_add(3, 1); sched_add(5, 0); sched_add(6, 2);
        frame(1'b1, 1'b1);

        // Out-of-order and simultaneous pulses, plus a repeat on neuron 0.
        s_n = 0;
        sched_add(2, 2); sched_add(2, 0); sched_add(4, 0); sched_add(7, 1);
        frame(1'b1, 1'b0);

        // Timeout: neuron 1 never reports.
        s_n = 0;
        sched_add(2, 0); sched_add(2, 2);
        frame(1'b0, 1'b1);

        // A later healthy frame keeps the sticky error.
        s_n = 0;
        sched_add(1, 2); sched_add(3, 0); sched_add(3, 1);
        frame(1'b1, 1'b1);

        // Reset in the middle of the burst, while word 2 is on the bus.
        new_vec();
        send_vec(1'b0);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            nrn_outvalid = '0;
            if (nrn_valid) cnt++;
            if (cnt == 3) break;
        end
        chk("midrst_word2", 32'(nrn_data), 32'(vec[2]));
        rst = 1'b0;
        #1;
        chk("midrst_nrn_valid", 32'(nrn_valid), 32'(0));
        chk("midrst_nrn_data", 32'(nrn_data), 32'(0));
        chk("midrst_busy", 32'(busy), 32'(0));
        chk("midrst_err", 32'(err), 32'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        err_model = 1'b0;
        @(negedge clk);
        chk("midrst_in_ready", 32'(in_ready), 32'(1));

        // Next frame broadcasts the new vector from word 0.
        s_n = 0;
        sched_add(1, 0); sched_add(1, 1); sched_add(1, 2);
        frame(1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
